writeback_stage: RTL

- Final pipeline stage of the single-IPC core. Takes an executed instruction (result, ALU flags, 3-bit effect code, destination) and decides whether its result is stored.
- Commits the result either to the register file in one cycle, or to data memory through a req/ack handshake that stalls upstream.
- Holds the architectural flags register.

---
 rtl/core_pkg.sv | 43 ++++
 rtl/wb_mem_port.sv | 72 +++++++
 rtl/writeback_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the writeback stage: effect codes, flag bit positions,
// memory-port state encoding and the store-condition evaluator.
package core_pkg;

  localparam logic [2:0] EFFECT_EQ     = 3'd0;
  localparam logic [2:0] EFFECT_NE     = 3'd1;
  localparam logic [2:0] EFFECT_GT     = 3'd2;
  localparam logic [2:0] EFFECT_ALWAYS = 3'd3;
  localparam logic [2:0] EFFECT_PL     = 3'd4;
  localparam logic [2:0] EFFECT_MI     = 3'd5;
  localparam logic [2:0] EFFECT_VC     = 3'd6;
  localparam logic [2:0] EFFECT_NEVER  = 3'd7;

  localparam int FLAG_OVERFLOW = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_NEGATIVE = 3;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_MEM_WAIT = 1'b1
  } wb_state_t;

  // Only Z, N and V take part in the condition, so they are passed individually.
  function automatic logic store_taken(input logic [2:0] effect,
                                       input logic z, input logic n, input logic v);
    logic taken;
    taken = 1'b0;
    case (effect)
      EFFECT_EQ:     taken = z;
      EFFECT_NE:     taken = ~z;
      EFFECT_GT:     taken = ~z & ~n;
      EFFECT_ALWAYS: taken = 1'b1;
      EFFECT_PL:     taken = ~n;
      EFFECT_MI:     taken = n;
      EFFECT_VC:     taken = ~v;
      EFFECT_NEVER:  taken = 1'b0;
      default:       taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/wb_mem_port.sv
// Memory write port of the writeback stage: holds one request stable until the
// memory acknowledges it, and can chain a new request on the acknowledging edge.
module wb_mem_port
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [DATA_WIDTH-1:0] i_start_data,
  input  logic                  i_mem_ack,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_busy,
  output logic                  o_done
);

  wb_state_t             r_state;
  wb_state_t             w_state_next;
  logic                  w_load;
  logic                  w_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      WB_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = WB_MEM_WAIT;
        end
      end
      WB_MEM_WAIT: begin
        // A start is only honoured on the acknowledging edge; the request is otherwise frozen.
        if (i_mem_ack) begin
          w_done       = 1'b1;
          w_load       = i_start;
          w_state_next = i_start ? WB_MEM_WAIT : WB_IDLE;
        end
      end
      default: w_state_next = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= WB_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_addr  <= i_start_addr;
        r_wdata <= i_start_data;
      end
    end
  end

  assign o_mem_req   = (r_state == WB_MEM_WAIT);
  assign o_busy      = (r_state == WB_MEM_WAIT);
  assign o_done      = w_done;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: evaluates the store condition, commits to the register
// file or to memory, keeps the architectural flags and signals retirement.
module writeback_stage
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int REG_BITS   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_effect,
  input  logic [4:0]            in_flags,
  input  logic                  in_update_flags,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_dest_mem,
  input  logic [REG_BITS-1:0]   in_dest_reg,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  reg_we,
  output logic [REG_BITS-1:0]   reg_waddr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic [4:0]            flags_q,
  output logic                  retire
);

  logic                  w_accept;
  logic                  w_take;
  logic                  w_mem_start;
  logic                  w_reg_write;
  logic                  w_retire_direct;
  logic                  w_mem_busy;
  logic                  w_mem_done;
  logic [1:0]            w_retire_events;

  logic                  r_reg_we;
  logic [REG_BITS-1:0]   r_reg_waddr;
  logic [DATA_WIDTH-1:0] r_reg_wdata;
  logic [4:0]            r_flags;
  logic                  r_retire;
  logic                  r_retire_pending;

  assign in_ready    = ~w_mem_busy | mem_ack;
  assign w_accept    = in_valid & in_ready;
  assign w_take      = store_taken(in_effect, in_flags[FLAG_ZERO],
                                   in_flags[FLAG_NEGATIVE], in_flags[FLAG_OVERFLOW]);
  assign w_mem_start = w_accept & w_take & in_dest_mem;
  assign w_reg_write = w_accept & w_take & ~in_dest_mem;
  assign w_retire_direct = w_accept & ~w_mem_start;

  // A memory completion and a register/skip accept can land on the same edge;
  // the second retire is deferred one cycle so every instruction gets its pulse.
  assign w_retire_events = {1'b0, w_retire_direct} + {1'b0, w_mem_done}
                         + {1'b0, r_retire_pending};

  wb_mem_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_port (
    .clock        (clock),
    .reset_n      (reset_n),
    .i_start      (w_mem_start),
    .i_start_addr (in_addr),
    .i_start_data (in_data),
    .i_mem_ack    (mem_ack),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_busy       (w_mem_busy),
    .o_done       (w_mem_done)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_reg_we         <= 1'b0;
      r_reg_waddr      <= '0;
      r_reg_wdata      <= '0;
      r_flags          <= '0;
      r_retire         <= 1'b0;
      r_retire_pending <= 1'b0;
    end else begin
      r_reg_we <= w_reg_write;
      if (w_reg_write) begin
        r_reg_waddr <= in_dest_reg;
        r_reg_wdata <= in_data;
      end
      if (w_accept && in_update_flags) begin
        r_flags <= in_flags;
      end
      r_retire         <= (w_retire_events != 2'd0);
      r_retire_pending <= w_retire_events[1];
    end
  end

  assign reg_we    = r_reg_we;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = r_reg_wdata;
  assign flags_q   = r_flags;
  assign retire    = r_retire;

endmodule
